hdmi_video_timing: RTL and testbench

// - Video timing controller and sequencer for the three TMDS channel encoders.
// - Generates the raster position and the de/vh control for the encoders.
// - Pulls pixels from an upstream source over a ready/valid handshake.
// - Drives registered rgb, de and vh one stage ahead of the encoders.
// - Channel 0 takes vh; channels 1 and 2 take vh = 2'b00.

---
 rtl/hdmi_video_timing_if.sv | 27 ++
 rtl/hdmi_video_timing.sv | 123 ++++++++++++
 tb/tb_hdmi_video_timing.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/hdmi_video_timing_if.sv
// Pixel stream from the upstream source into the video timing controller.
// Latency: none (wires only); a pixel transfers on the cycle pix_valid && pix_ready.
// Backpressure: pix_ready is high only during active video; the sink never stalls otherwise.
//
// Signals:
//   pix_valid  source -> sink  pixel available
//   pix_data   source -> sink  {R[23:16], G[15:8], B[7:0]}
//   pix_ready  sink -> source  pixel accepted this cycle when pix_valid=1
interface hdmi_video_timing_if;
    logic        pix_valid;
    logic [23:0] pix_data;
    logic        pix_ready;

    // Upstream pixel source.
    modport master (
        output pix_valid,
        output pix_data,
        input  pix_ready
    );

    // Timing controller pulling pixels.
    modport slave (
        input  pix_valid,
        input  pix_data,
        output pix_ready
    );
endinterface

// File: rtl/hdmi_video_timing.sv
// Video timing controller and sequencer feeding the three TMDS channel encoders.
// Latency: 1 clock from counter state to the registered de/vh/rgb/frame_start outputs.
// Backpressure: none accepted; a pixel missing when needed is replaced by black and flagged.
//
// Ports:
//   clk, rst_n    pixel clock (rising edge), asynchronous active-low reset
//   enable        1 = run the raster, 0 = hold the counters at (0,0) and blank the outputs
//   pix           pixel stream slave (pix_valid, pix_data, pix_ready)
//   de            data enable to all encoders
//   vh            {vsync, hsync} for the channel-0 encoder (channels 1/2 take 2'b00)
//   rgb           pixel to the encoders, black outside transfers
//   frame_start   one-cycle pulse coincident with the first de=1 of a frame
//   underflow     sticky flag: an active pixel was needed but none was offered
//   hcnt, vcnt    raster position of the cycle currently being processed
module hdmi_video_timing #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    hdmi_video_timing_if.slave       pix,
    output logic                     de,
    output logic [1:0]               vh,
    output logic [23:0]              rgb,
    output logic                     frame_start,
    output logic                     underflow,
    output logic [11:0]              hcnt,
    output logic [10:0]              vcnt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Region boundaries sized to the counters so every compare is width-matched.
    localparam logic [11:0] H_ACT_END = 12'(H_ACTIVE);
    localparam logic [11:0] HS_START  = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS_END    = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] H_LAST    = 12'(H_TOTAL - 1);

    localparam logic [10:0] V_ACT_END = 11'(V_ACTIVE);
    localparam logic [10:0] VS_START  = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END    = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [10:0] V_LAST    = 11'(V_TOTAL - 1);

    localparam logic [23:0] BLACK = 24'h000000;

    logic active;
    logic transfer;
    logic hsync_on;
    logic vsync_on;
    logic first_pixel;
    logic h_wrap;
    logic v_wrap;

    // Everything is qualified by enable so that dropping enable blanks the
    // next output cycle even though the counters still hold the old position.
    always_comb begin
        active      = enable && (hcnt < H_ACT_END) && (vcnt < V_ACT_END);
        transfer    = active && pix.pix_valid;
        hsync_on    = enable && (hcnt >= HS_START) && (hcnt < HS_END);
        vsync_on    = enable && (vcnt >= VS_START) && (vcnt < VS_END);
        first_pixel = enable && (hcnt == 12'd0) && (vcnt == 11'd0);
        h_wrap      = (hcnt == H_LAST);
        v_wrap      = (vcnt == V_LAST);
    end

    // Only ever ready in active video, so nothing transfers during blanking.
    assign pix.pix_ready = active;

    // Raster counters. enable=0 takes priority over any wrap so that the first
    // enabled cycle afterwards is always pixel 0 of line 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt <= 12'd0;
            vcnt <= 11'd0;
        end else if (!enable) begin
            hcnt <= 12'd0;
            vcnt <= 11'd0;
        end else if (h_wrap) begin
            hcnt <= 12'd0;
            vcnt <= v_wrap ? 11'd0 : vcnt + 11'd1;
        end else begin
            hcnt <= hcnt + 12'd1;
        end
    end

    // Output stage, one register ahead of the encoders.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            de          <= 1'b0;
            rgb         <= BLACK;
            vh          <= {~VS_POL, ~HS_POL};
            frame_start <= 1'b0;
        end else begin
            de          <= active;
            rgb         <= transfer ? pix.pix_data : BLACK;
            vh[0]       <= hsync_on ? HS_POL : ~HS_POL;
            vh[1]       <= vsync_on ? VS_POL : ~VS_POL;
            frame_start <= first_pixel;
        end
    end

    // Sticky underflow; dropping enable is the software-visible way to clear it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underflow <= 1'b0;
        end else if (!enable) begin
            underflow <= 1'b0;
        end else if (active && !pix.pix_valid) begin
            underflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_hdmi_video_timing.sv
// Directed bench for hdmi_video_timing on a reduced raster (32 x 19) so that a
// whole frame plus the enable and reset scenarios fit in well under 1000 clocks.
// Geometry: H = 16 active / 4 fp / 6 sync / 6 bp; V = 12 active / 2 fp / 2 sync / 3 bp.
module tb_hdmi_video_timing;

    localparam int HA = 16, HF = 4, HS = 6, HB = 6, HT = 32;
    localparam int VA = 12, VF = 2, VS = 2, VB = 3, VT = 19;
    localparam int FRAME = HT * VT;          // 608 clocks
    localparam int UF_P  = 5 * HT + 5;       // pixel 5 of line 5
    localparam int DROP_P = FRAME + 7 * HT + 10; // hcnt=10, vcnt=7 of the second frame

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        de;
    logic [1:0]  vh;
    logic [23:0] rgb;
    logic        frame_start;
    logic        underflow;
    logic [11:0] hcnt;
    logic [10:0] vcnt;

    int          compares = 0;
    int          mismatches = 0;
    int          cur_p = -1;
    logic [23:0] seq;
    bit          uf_exp = 1'b0;
    int          de_cnt = 0;
    int          vs_cnt = 0;
    int          fs_cnt = 0;

    hdmi_video_timing_if pix_if();

    hdmi_video_timing #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HS_POL(1'b0), .VS_POL(1'b0)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .pix         (pix_if),
        .de          (de),
        .vh          (vh),
        .rgb         (rgb),
        .frame_start (frame_start),
        .underflow   (underflow),
        .hcnt        (hcnt),
        .vcnt        (vcnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compares++;
        assert (obs === exp) else begin
            mismatches++;
            $error("FAIL %s at p=%0d: got %0h, want %0h", tag, cur_p, obs, exp);
        end
    endtask

    // Blanked/idle output state expected after reset or an enable drop.
    task automatic check_idle(input string tag);
        check({tag, "_de"},   32'(de), 0);
        check({tag, "_rgb"},  32'(rgb), 0);
        check({tag, "_vh"},   32'(vh), 3);
        check({tag, "_fs"},   32'(frame_start), 0);
        check({tag, "_uf"},   32'(underflow), 0);
        check({tag, "_hcnt"}, 32'(hcnt), 0);
        check({tag, "_vcnt"}, 32'(vcnt), 0);
    endtask

    // One enabled clock at raster position p (counted from the enabling edge).
    // Called at posedge+1; leaves time at the following posedge+1.
    task automatic step(input int p, input bit vld);
        int h, v, hn, vn;
        bit act;
        h   = p % HT;
        v   = (p / HT) % VT;
        act = (h < HA) && (v < VA);
        cur_p = p;
        pix_if.pix_valid = vld;
        pix_if.pix_data  = seq;
        #1;
        check("pix_ready", 32'(pix_if.pix_ready), 32'(act));
        @(posedge clk);
        #1;
        check("de", 32'(de), 32'(act));
        if (act && vld) begin
            check("rgb", 32'(rgb), 32'(seq));
            seq = seq + 24'd1;
        end else begin
            check("rgb_black", 32'(rgb), 0);
        end
        if (act && !vld) uf_exp = 1'b1;
        check("underflow", 32'(underflow), 32'(uf_exp));
        check("hsync", 32'(vh[0]), 32'(!((h >= HA + HF) && (h < HA + HF + HS))));
        check("vsync", 32'(vh[1]), 32'(!((v >= VA + VF) && (v < VA + VF + VS))));
        check("frame_start", 32'(frame_start), 32'((h == 0) && (v == 0)));
        hn = (p + 1) % HT;
        vn = ((p + 1) / HT) % VT;
        check("hcnt", 32'(hcnt), 32'(hn));
        check("vcnt", 32'(vcnt), 32'(vn));
        if (de) de_cnt++;
        if (!vh[1]) vs_cnt++;
        if (frame_start) fs_cnt++;
    endtask

    initial begin
        pix_if.pix_valid = 1'b0;
        pix_if.pix_data  = 24'h0;
        seq = 24'hA00000;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset");

        // Out of reset but not yet enabled: still idle.
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_idle("disabled");

        // First frame with one missing pixel at line 5, pixel 5.
        enable = 1'b1;
        for (int p = 0; p < FRAME; p++) step(p, p != UF_P);
        cur_p = FRAME;
        check("frame_de_total", 32'(de_cnt), 32'(HA * VA));
        check("frame_vsync_clocks", 32'(vs_cnt), 32'(VS * HT));
        check("frame_start_count", 32'(fs_cnt), 1);

        // Second frame: wrap at (HT-1, VT-1) must pulse frame_start again.
        for (int p = FRAME; p < DROP_P; p++) step(p, 1'b1);

        // Enable drop in the middle of an active line.
        cur_p = DROP_P;
        enable = 1'b0;
        pix_if.pix_valid = 1'b1;
        #1;
        check("drop_pix_ready", 32'(pix_if.pix_ready), 0);
        @(posedge clk);
        #1;
        uf_exp = 1'b0;
        check_idle("drop");
        repeat (2) @(posedge clk);
        #1;
        check_idle("hold");

        // Re-enable restarts at (0,0) with frame_start on the first output cycle.
        enable = 1'b1;
        for (int p = 0; p < 40; p++) step(p, p != 3);

        // Asynchronous reset away from any clock edge, mid-line with underflow set.
        #3;
        cur_p = -2;
        rst_n = 1'b0;
        #1;
        check_idle("async_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, mismatches);
        $finish;
    end

endmodule
